// File: rtl/pwm_duty_ramp_ctrl_if.sv
// ============================================================================
// Module      : pwm_duty_ramp_ctrl_if
// Description : Configuration handshake bundle (valid/ready, target, step).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pwm_duty_ramp_ctrl_if #(
  parameter int DUTY_W = 8,
  parameter int STEP_W = 4
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [DUTY_W-1:0] cfg_target;
  logic [STEP_W-1:0] cfg_step;

  modport master (output cfg_valid, output cfg_target, output cfg_step, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_target, input cfg_step, output cfg_ready);
endinterface

`default_nettype wire

// File: rtl/pwm_duty_ramp_ctrl.sv
// ============================================================================
// Module      : pwm_duty_ramp_ctrl
// Description : Steps a PWM duty toward a target once per prescaler tick,
//               committing new values only on PWM period boundaries.
//               Optional abort input enabled by PWM_RAMP_ABORT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_duty_ramp_ctrl #(
  parameter int DUTY_W = 8,
  parameter int STEP_W = 4
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              tick,
  input  wire logic              period_end,
`ifdef PWM_RAMP_ABORT_EN
  input  wire logic              abort,
`endif
  pwm_duty_ramp_ctrl_if.slave    cfg,
  output logic                   timer_en,
  output logic                   timer_clr,
  output logic [DUTY_W-1:0]      duty_out,
  output logic                   duty_load,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RAMP = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [DUTY_W-1:0] r_target;
  logic [DUTY_W-1:0] r_pending;
  logic [DUTY_W-1:0] r_duty;
  logic [STEP_W-1:0] r_step;
  logic              r_timer_clr;
  logic              r_duty_load;
  logic              r_done;

  logic              w_cfg_ready;
  logic              w_accept;
  logic              w_at_target;
  logic              w_take_tick;
  logic              w_commit;
  logic              w_final;
  logic              w_abort;
  logic              w_abort_busy;
  logic              w_up;
  logic [DUTY_W:0]   w_step_ext;
  logic [DUTY_W:0]   w_diff;
  logic [DUTY_W:0]   w_next_duty;

`ifdef PWM_RAMP_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_at_target = (cfg.cfg_target == r_duty);
  assign w_final     = (r_pending == r_target);

  // Extended-width arithmetic so a step past the target never wraps.
  always_comb begin
    w_step_ext  = (r_step == '0) ? {{DUTY_W{1'b0}}, 1'b1}
                                 : {{(DUTY_W+1-STEP_W){1'b0}}, r_step};
    w_up        = ({1'b0, r_target} >= {1'b0, r_duty});
    w_diff      = w_up ? ({1'b0, r_target} - {1'b0, r_duty})
                       : ({1'b0, r_duty} - {1'b0, r_target});
    w_next_duty = {1'b0, r_target};
    if (w_diff > w_step_ext) begin
      w_next_duty = w_up ? ({1'b0, r_duty} + w_step_ext)
                         : ({1'b0, r_duty} - w_step_ext);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_take_tick  = 1'b0;
    w_commit     = 1'b0;
    w_abort_busy = 1'b0;
    w_cfg_ready  = 1'b0;
    busy         = 1'b0;
    timer_en     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cfg_ready = 1'b1;
        w_accept    = cfg.cfg_valid;
        if (w_accept && !w_at_target) w_state_next = S_RAMP;
      end
      S_RAMP: begin
        busy     = 1'b1;
        timer_en = 1'b1;
        if (w_abort) begin
          w_abort_busy = 1'b1;
          w_state_next = S_IDLE;
        end else if (tick && !r_timer_clr) begin
          w_take_tick  = 1'b1;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (w_abort) begin
          w_abort_busy = 1'b1;
          w_state_next = S_IDLE;
        end else if (period_end) begin
          w_commit     = 1'b1;
          w_state_next = w_final ? S_IDLE : S_RAMP;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_target    <= '0;
      r_step      <= '0;
      r_pending   <= '0;
      r_duty      <= '0;
      r_timer_clr <= 1'b0;
      r_duty_load <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_timer_clr <= w_accept && !w_at_target;
      r_duty_load <= w_commit;
      r_done      <= (w_accept && w_at_target) || (w_commit && w_final);
      if (w_accept) begin
        r_target <= cfg.cfg_target;
        r_step   <= cfg.cfg_step;
      end
      if (w_take_tick)       r_pending <= w_next_duty[DUTY_W-1:0];
      else if (w_abort_busy) r_pending <= '0;
      if (w_commit) r_duty <= r_pending;
    end
  end

  assign cfg.cfg_ready = w_cfg_ready;
  assign timer_clr     = r_timer_clr;
  assign duty_out      = r_duty;
  assign duty_load     = r_duty_load;
  assign done          = r_done;

endmodule

`default_nettype wire

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// ============================================================================
// Module      : tb_pwm_duty_ramp_ctrl
// Description : Directed self-checking bench for pwm_duty_ramp_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_duty_ramp_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       period_end;
  logic       abort;
  logic       timer_en;
  logic       timer_clr;
  logic [7:0] duty_out;
  logic       duty_load;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  logic [7:0] loads[$];
  int         ndone;
  int         done_with_load;
  bit         tmo;

  pwm_duty_ramp_ctrl_if #(.DUTY_W(8), .STEP_W(4)) cfg_if ();

  pwm_duty_ramp_ctrl #(.DUTY_W(8), .STEP_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .period_end (period_end),
`ifdef PWM_RAMP_ABORT_EN
    .abort      (abort),
`endif
    .cfg        (cfg_if),
    .timer_en   (timer_en),
    .timer_clr  (timer_clr),
    .duty_out   (duty_out),
    .duty_load  (duty_load),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input logic [7:0] t, input logic [3:0] s);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_target = t;
    cfg_if.cfg_step   = s;
    cyc();
    cfg_if.cfg_valid  = 1'b0;
  endtask

  // Periodic tick/period_end stimulus; records every committed duty value.
  task automatic run_ramp(input int tp, input int pp, input int maxc);
    loads.delete();
    ndone = 0;
    done_with_load = 0;
    tmo = 1'b1;
    for (int c = 0; c < maxc; c++) begin
      tick       = (c % tp == tp - 1);
      period_end = (c % pp == pp - 1);
      cyc();
      tick       = 1'b0;
      period_end = 1'b0;
      if (duty_load) loads.push_back(duty_out);
      if (done) begin
        ndone++;
        if (duty_load) done_with_load++;
        tmo = 1'b0;
        break;
      end
    end
    tick       = 1'b0;
    period_end = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    checks++;
    if (duty_out !== 8'd0 || cfg_if.cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_duty_ready: duty_out=%0d ready=%b, expected 0 and 1", duty_out, cfg_if.cfg_ready);
    end
    checks++;
    if ({duty_load, done, busy, timer_en, timer_clr} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: {load,done,busy,en,clr}=%b, expected 00000",
               {duty_load, done, busy, timer_en, timer_clr});
    end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_up();
    logic [7:0] exp[3] = '{8'd4, 8'd8, 8'd10};
    bit ok;
    send_cfg(8'd10, 4'd4);
    checks++;
    if ({busy, timer_clr, cfg_if.cfg_ready} !== 3'b110) begin
      errors++;
      $display("FAIL up_accept: {busy,clr,ready}=%b, expected 110", {busy, timer_clr, cfg_if.cfg_ready});
    end
    cyc();
    checks++;
    if ({timer_clr, timer_en} !== 2'b01) begin
      errors++;
      $display("FAIL up_clr_pulse: {clr,en}=%b, expected 01", {timer_clr, timer_en});
    end
    run_ramp(5, 8, 200);
    ok = !tmo && loads.size() == 3;
    for (int i = 0; i < 3; i++) if (ok && loads[i] !== exp[i]) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL up_seq: got %0d loads (timeout=%0b), expected 3 loads 4,8,10", loads.size(), tmo);
    end
    checks++;
    if (ndone != 1 || done_with_load != 1) begin
      errors++;
      $display("FAIL up_done: done=%0d with_load=%0d, expected 1 and 1", ndone, done_with_load);
    end
    cyc();
    checks++;
    if ({done, duty_load, busy, cfg_if.cfg_ready} !== 4'b0001 || duty_out !== 8'd10) begin
      errors++;
      $display("FAIL up_after: {done,load,busy,ready}=%b duty=%0d, expected 0001 and 10",
               {done, duty_load, busy, cfg_if.cfg_ready}, duty_out);
    end
  endtask

  task automatic test_down();
    logic [7:0] exp[4] = '{8'd7, 8'd4, 8'd1, 8'd0};
    bit ok;
    send_cfg(8'd0, 4'd3);
    run_ramp(5, 8, 300);
    ok = !tmo && loads.size() == 4 && done_with_load == 1;
    for (int i = 0; i < 4; i++) if (ok && loads[i] !== exp[i]) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL down_seq: got %0d loads duty=%0d (timeout=%0b), expected 7,4,1,0", loads.size(), duty_out, tmo);
    end
  endtask

  task automatic test_step_zero();
    bit ok;
    send_cfg(8'd2, 4'd0);
    run_ramp(5, 8, 200);
    ok = !tmo && loads.size() == 2;
    if (ok) ok = (loads[0] === 8'd1) && (loads[1] === 8'd2);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL step_zero_seq: got %0d loads duty=%0d, expected 1,2", loads.size(), duty_out);
    end
  endtask

  task automatic test_target_equal();
    send_cfg(8'd2, 4'd5);
    checks++;
    if ({done, duty_load, busy, timer_clr, cfg_if.cfg_ready} !== 5'b10001) begin
      errors++;
      $display("FAIL equal_done: {done,load,busy,clr,ready}=%b, expected 10001",
               {done, duty_load, busy, timer_clr, cfg_if.cfg_ready});
    end
    cyc();
    checks++;
    if (done !== 1'b0 || duty_out !== 8'd2) begin
      errors++;
      $display("FAIL equal_after: done=%b duty=%0d, expected 0 and 2", done, duty_out);
    end
  endtask

  task automatic test_simultaneous();
    bit quiet;
    send_cfg(8'd7, 4'd5);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    checks++;
    if (timer_en !== 1'b1) begin
      errors++;
      $display("FAIL clr_tick_ignored: timer_en=%b, expected 1", timer_en);
    end
    tick = 1'b1;
    period_end = 1'b1;
    cyc();
    tick = 1'b0;
    period_end = 1'b0;
    checks++;
    if ({busy, timer_en, duty_load} !== 3'b100 || duty_out !== 8'd2) begin
      errors++;
      $display("FAIL simul_no_commit: {busy,en,load}=%b duty=%0d, expected 100 and 2",
               {busy, timer_en, duty_load}, duty_out);
    end
    quiet = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (duty_load !== 1'b0 || duty_out !== 8'd2) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL simul_wait: duty=%0d load=%b, expected 2 and 0", duty_out, duty_load);
    end
    period_end = 1'b1;
    cyc();
    period_end = 1'b0;
    checks++;
    if ({duty_load, done} !== 2'b11 || duty_out !== 8'd7) begin
      errors++;
      $display("FAIL simul_commit: {load,done}=%b duty=%0d, expected 11 and 7", {duty_load, done}, duty_out);
    end
  endtask

  task automatic test_extra_ticks();
    send_cfg(8'd15, 4'd4);
    cyc();
    tick = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    tick = 1'b0;
    checks++;
    if (timer_en !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL extra_wait_state: en=%b busy=%b, expected 0 and 1", timer_en, busy);
    end
    period_end = 1'b1;
    cyc();
    checks++;
    if ({duty_load, done, timer_en} !== 3'b101 || duty_out !== 8'd11) begin
      errors++;
      $display("FAIL extra_first: {load,done,en}=%b duty=%0d, expected 101 and 11",
               {duty_load, done, timer_en}, duty_out);
    end
    cyc();
    period_end = 1'b0;
    checks++;
    if (duty_load !== 1'b0 || duty_out !== 8'd11) begin
      errors++;
      $display("FAIL extra_pe_in_ramp: load=%b duty=%0d, expected 0 and 11", duty_load, duty_out);
    end
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    period_end = 1'b1;
    cyc();
    period_end = 1'b0;
    checks++;
    if ({duty_load, done} !== 2'b11 || duty_out !== 8'd15) begin
      errors++;
      $display("FAIL extra_final: {load,done}=%b duty=%0d, expected 11 and 15", {duty_load, done}, duty_out);
    end
  endtask

  task automatic test_hold_valid();
    bit held;
    bit ok;
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_target = 8'd20;
    cfg_if.cfg_step   = 4'd10;
    cyc();
    cfg_if.cfg_target = 8'd3;
    cfg_if.cfg_step   = 4'd15;
    held = 1'b1;
    cyc();
    if (busy !== 1'b1 || cfg_if.cfg_ready !== 1'b0) held = 1'b0;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    if (busy !== 1'b1 || cfg_if.cfg_ready !== 1'b0) held = 1'b0;
    period_end = 1'b1;
    cyc();
    period_end = 1'b0;
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL hold_busy: busy/ready changed during ramp, expected busy=1 ready=0");
    end
    checks++;
    if ({done, cfg_if.cfg_ready, busy} !== 3'b110 || duty_out !== 8'd20) begin
      errors++;
      $display("FAIL hold_done: {done,ready,busy}=%b duty=%0d, expected 110 and 20",
               {done, cfg_if.cfg_ready, busy}, duty_out);
    end
    cyc();
    cfg_if.cfg_valid = 1'b0;
    checks++;
    if ({busy, timer_clr} !== 2'b11) begin
      errors++;
      $display("FAIL hold_accept: {busy,clr}=%b, expected 11", {busy, timer_clr});
    end
    run_ramp(5, 8, 300);
    ok = !tmo && loads.size() == 2;
    if (ok) ok = (loads[0] === 8'd5) && (loads[1] === 8'd3);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL hold_seq: got %0d loads duty=%0d, expected 5,3", loads.size(), duty_out);
    end
  endtask

  task automatic test_async_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    send_cfg(8'd10, 4'd4);
    cyc();
    for (int i = 0; i < 2; i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      period_end = 1'b1;
      cyc();
      period_end = 1'b0;
    end
    checks++;
    if (duty_out !== 8'd8 || busy !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: duty=%0d busy=%b, expected 8 and 1", duty_out, busy);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (duty_out !== 8'd0 || cfg_if.cfg_ready !== 1'b1 ||
        {busy, timer_en, timer_clr, duty_load, done} !== 5'b0) begin
      errors++;
      $display("FAIL areset_now: duty=%0d ready=%b flags=%b, expected 0, 1, 00000",
               duty_out, cfg_if.cfg_ready, {busy, timer_en, timer_clr, duty_load, done});
    end
    cyc();
    reset = 1'b0;
    cyc();
  endtask

`ifdef PWM_RAMP_ABORT_EN
  task automatic test_abort();
    send_cfg(8'd10, 4'd4);
    cyc();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    period_end = 1'b1;
    cyc();
    period_end = 1'b0;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    abort = 1'b1;
    period_end = 1'b1;
    cyc();
    abort = 1'b0;
    period_end = 1'b0;
    checks++;
    if ({cfg_if.cfg_ready, busy, duty_load, done} !== 4'b1000 || duty_out !== 8'd4) begin
      errors++;
      $display("FAIL abort_idle: {ready,busy,load,done}=%b duty=%0d, expected 1000 and 4",
               {cfg_if.cfg_ready, busy, duty_load, done}, duty_out);
    end
    cyc();
    checks++;
    if (done !== 1'b0 || duty_out !== 8'd4) begin
      errors++;
      $display("FAIL abort_after: done=%b duty=%0d, expected 0 and 4", done, duty_out);
    end
  endtask
`endif

  initial begin
    reset             = 1'b1;
    tick              = 1'b0;
    period_end        = 1'b0;
    abort             = 1'b0;
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_target = 8'd0;
    cfg_if.cfg_step   = 4'd0;
    test_reset();
    test_up();
    test_down();
    test_step_zero();
    test_target_equal();
    test_simultaneous();
    test_extra_ticks();
    test_hold_valid();
    test_async_reset();
`ifdef PWM_RAMP_ABORT_EN
    test_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
